// File: rtl/fpu_pkg.sv
// Shared types and constants for the pipelined FPU adder/subtractor.
// Status bit positions, FSM state encoding, rounding-mode codes and the exponent bias.
package fpu_pkg;

   localparam int ST_EXACT   = 0;
   localparam int ST_OVF     = 1;
   localparam int ST_UNF     = 2;
   localparam int ST_INEXACT = 3;

   localparam logic RND_RNE   = 1'b0;
   localparam logic RND_TRUNC = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
// Scanning from the LSB upward lets the highest set bit have the final say.
module fpu_lzc #(
   parameter  int WIDTH = 28,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data_i,
   output logic [CNT_W-1:0] count_o
);

   always_comb begin
      count_o = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Multi-cycle floating-point adder/subtractor with valid/ready handshakes.
// One operation at a time walks UNPACK, ALIGN, ADD, NORM, ROUND, then waits in DONE.
module fpu_addsub_pipe
   import fpu_pkg::*;
#(
   parameter  int EXP_W  = 7,
   parameter  int FRAC_W = 24,
   localparam int W      = 1 + EXP_W + FRAC_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] op_a_in,
   input  logic [W-1:0] op_b_in,
   input  logic         op_sel,
   input  logic         rnd_mode_in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] data_out,
   output logic [3:0]   status_out,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam int MAN_W  = FRAC_W + 1;       // mantissa with hidden bit
   localparam int EXT_W  = MAN_W + 3;        // plus guard, round, sticky
   localparam int SUM_W  = EXT_W + 1;        // plus carry-out
   localparam int WIDE_W = 2 * MAN_W + 2;
   localparam int EXP_SW = EXP_W + 2;        // signed working exponent
   localparam int LZ_W   = $clog2(EXT_W + 1);

   localparam logic [EXP_W-1:0]         EXP_ONES = '1;
   localparam logic signed [EXP_SW-1:0] EXP_MAX  = EXP_SW'((2 ** EXP_W) - 1);
   localparam logic signed [EXP_SW-1:0] EXP_ONE  = EXP_SW'(1);

   state_t state_q, state_d;

   logic [W-1:0]              a_q, b_q, short_data_q, data_q;
   logic                      sel_q, rnd_q, sign_l_q, eff_sub_q, sat_q, short_q, zero_q;
   logic [EXP_W-1:0]          exp_l_q, exp_s_q;
   logic [MAN_W-1:0]          man_l_q, man_s_q;
   logic [EXT_W-1:0]          ext_s_q, norm_q;
   logic [SUM_W-1:0]          sum_q;
   logic signed [EXP_SW-1:0]  exp_q;
   logic [3:0]                status_q;

   // FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case can infer a latch.
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = S_UNPACK;
         end
         S_UNPACK: state_d = S_ALIGN;
         S_ALIGN:  state_d = S_ADD;
         S_ADD:    state_d = S_NORM;
         S_NORM:   state_d = S_ROUND;
         S_ROUND:  state_d = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // UNPACK: effective sign of B, hidden bit, magnitude ordering
   logic              sa, sb, a_big;
   logic [EXP_W-1:0]  ea, eb;
   logic [FRAC_W-1:0] fa, fb;

   assign sa    = a_q[W-1];
   assign sb    = b_q[W-1] ^ sel_q;
   assign ea    = a_q[W-2:FRAC_W];
   assign eb    = b_q[W-2:FRAC_W];
   assign fa    = a_q[FRAC_W-1:0];
   assign fb    = b_q[FRAC_W-1:0];
   assign a_big = a_q[W-2:0] >= b_q[W-2:0];

   // ALIGN: shifted-out bits below the round position collapse into sticky
   logic [EXP_W-1:0]  diff;
   logic [WIDE_W-1:0] wide;
   logic [EXT_W-1:0]  aligned;

   assign diff    = exp_l_q - exp_s_q;
   assign wide    = {man_s_q, {(MAN_W + 2){1'b0}}} >> diff;
   assign aligned = (int'(diff) >= MAN_W + 2) ? EXT_W'(1)
                                              : {wide[WIDE_W-1:MAN_W], |wide[MAN_W-1:0]};

   // ADD
   logic [SUM_W-1:0] sum;
   assign sum = eff_sub_q ? ({1'b0, man_l_q, 3'b000} - {1'b0, ext_s_q})
                          : ({1'b0, man_l_q, 3'b000} + {1'b0, ext_s_q});

   // NORM
   logic [LZ_W-1:0]          lz;
   logic [EXT_W-1:0]         norm;
   logic signed [EXP_SW-1:0] exp_n;

   fpu_lzc #(.WIDTH(EXT_W)) u_lzc (
      .data_i  (sum_q[EXT_W-1:0]),
      .count_o (lz)
   );

   always_comb begin
      if (sum_q[SUM_W-1]) begin
         norm  = {sum_q[SUM_W-1:2], |sum_q[1:0]};
         exp_n = exp_q + EXP_ONE;
      end else begin
         norm  = sum_q[EXT_W-1:0] << lz;
         exp_n = exp_q - $signed(EXP_SW'(lz));
      end
   end

   // ROUND and result classification
   logic                     inc;
   logic [MAN_W:0]           rounded;
   logic signed [EXP_SW-1:0] exp_r;
   logic [FRAC_W-1:0]        frac_r;
   logic [W-1:0]             data_d;
   logic [3:0]               status_d;

   assign inc     = (rnd_q == RND_RNE) & norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
   assign rounded = {1'b0, norm_q[EXT_W-1:3]} + {{MAN_W{1'b0}}, inc};
   assign exp_r   = exp_q + $signed({{(EXP_SW - 1){1'b0}}, rounded[MAN_W]});
   assign frac_r  = rounded[MAN_W] ? rounded[MAN_W-1:1] : rounded[FRAC_W-1:0];

   always_comb begin
      data_d   = '0;
      status_d = '0;
      if (sat_q) begin
         data_d           = {sign_l_q, EXP_ONES, {FRAC_W{1'b0}}};
         status_d[ST_OVF] = 1'b1;
      end else if (short_q) begin
         data_d             = short_data_q;
         status_d[ST_EXACT] = 1'b1;
      end else if (zero_q) begin
         status_d[ST_EXACT] = 1'b1;
      end else if (exp_r >= EXP_MAX) begin
         data_d           = {sign_l_q, EXP_ONES, {FRAC_W{1'b0}}};
         status_d[ST_OVF] = 1'b1;
      end else if (exp_r[EXP_SW-1] || exp_r == '0) begin
         data_d           = {sign_l_q, {(W - 1){1'b0}}};
         status_d[ST_UNF] = 1'b1;
      end else begin
         data_d = {sign_l_q, exp_r[EXP_W-1:0], frac_r};
         if (|norm_q[2:0]) status_d[ST_INEXACT] = 1'b1;
         else              status_d[ST_EXACT]   = 1'b1;
      end
   end

   // Datapath registers, each loaded only in the state that produces it.
   // NOTE: the datapath is reset along with the FSM so data_out/status_out read zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q          <= '0;
         b_q          <= '0;
         sel_q        <= 1'b0;
         rnd_q        <= 1'b0;
         sign_l_q     <= 1'b0;
         eff_sub_q    <= 1'b0;
         sat_q        <= 1'b0;
         short_q      <= 1'b0;
         short_data_q <= '0;
         exp_l_q      <= '0;
         exp_s_q      <= '0;
         man_l_q      <= '0;
         man_s_q      <= '0;
         ext_s_q      <= '0;
         sum_q        <= '0;
         exp_q        <= '0;
         norm_q       <= '0;
         zero_q       <= 1'b0;
         data_q       <= '0;
         status_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= op_a_in;
                  b_q   <= op_b_in;
                  sel_q <= op_sel;
                  rnd_q <= rnd_mode_in;
               end
            end
            S_UNPACK: begin
               sign_l_q     <= a_big ? sa : sb;
               eff_sub_q    <= sa ^ sb;
               exp_l_q      <= a_big ? ea : eb;
               exp_s_q      <= a_big ? eb : ea;
               man_l_q      <= {1'b1, a_big ? fa : fb};
               man_s_q      <= {1'b1, a_big ? fb : fa};
               sat_q        <= (ea == EXP_ONES) || (eb == EXP_ONES);
               short_q      <= (ea == '0) || (eb == '0);
               short_data_q <= (ea == '0) ? {sb, eb, fb} : a_q;
            end
            S_ALIGN: ext_s_q <= aligned;
            S_ADD: begin
               sum_q <= sum;
               exp_q <= $signed({2'b00, exp_l_q});
            end
            S_NORM: begin
               norm_q <= norm;
               exp_q  <= exp_n;
               zero_q <= (sum_q == '0);
            end
            S_ROUND: begin
               data_q   <= data_d;
               status_q <= status_d;
            end
            default: ;
         endcase
      end
   end

   assign data_out   = data_q;
   assign status_out = status_q;

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed plus randomized bench for fpu_addsub_pipe, checked against an exact-arithmetic model.
module tb_fpu_addsub_pipe;
   import fpu_pkg::*;

   localparam int EXP_W    = 7;
   localparam int FRAC_W   = 24;
   localparam int W        = 1 + EXP_W + FRAC_W;
   localparam int MAX_WAIT = 20;
   localparam int LAT      = 6;   // cycles from the accept cycle to the first out_valid cycle

   logic         clk;
   logic         rst;
   logic [W-1:0] op_a_in, op_b_in, data_out;
   logic         op_sel, rnd_mode_in, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]   status_out;

   int checks   = 0;
   int failures = 0;

   fpu_addsub_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .op_a_in     (op_a_in),
      .op_b_in     (op_b_in),
      .op_sel      (op_sel),
      .rnd_mode_in (rnd_mode_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .data_out    (data_out),
      .status_out  (status_out),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Exact reference: both magnitudes scaled to the smaller exponent as wide integers,
   // summed, then rounded to 25 significant bits.
   function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic sel, input logic rnd,
                                     output logic [31:0] d, output logic [3:0] st);
      logic         sa, sb, sign;
      int           ea, eb, emin, p, sh, e;
      logic [255:0] ma, mb, mag, kept, rem, half;
      sa = a[31];
      sb = b[31] ^ sel;
      ea = int'(a[30:24]);
      eb = int'(b[30:24]);
      d  = '0;
      st = '0;
      if (ea == 127 || eb == 127) begin
         sign = (a[30:0] >= b[30:0]) ? sa : sb;
         d = {sign, 7'h7f, 24'h0};
         st[ST_OVF] = 1'b1;
         return;
      end
      if (ea == 0) begin
         d = {sb, b[30:0]};
         st[ST_EXACT] = 1'b1;
         return;
      end
      if (eb == 0) begin
         d = a;
         st[ST_EXACT] = 1'b1;
         return;
      end
      emin = (ea < eb) ? ea : eb;
      ma = 256'({1'b1, a[23:0]}) << (ea - emin);
      mb = 256'({1'b1, b[23:0]}) << (eb - emin);
      if (sa == sb) begin
         mag = ma + mb; sign = sa;
      end else if (ma >= mb) begin
         mag = ma - mb; sign = sa;
      end else begin
         mag = mb - ma; sign = sb;
      end
      if (mag == '0) begin
         st[ST_EXACT] = 1'b1;
         return;
      end
      p = 0;
      for (int i = 0; i < 256; i++) if (mag[i]) p = i;
      sh  = p - 24;
      e   = emin + sh;
      rem = '0;
      if (sh > 0) begin
         kept = mag >> sh;
         rem  = mag - (kept << sh);
         half = 256'(1) << (sh - 1);
         if (rnd == RND_RNE && (rem > half || (rem == half && kept[0]))) kept = kept + 1;
      end else begin
         kept = mag << (-sh);
      end
      if (kept[25]) begin
         kept = kept >> 1;
         e++;
      end
      if (e >= 127) begin
         d = {sign, 7'h7f, 24'h0};
         st[ST_OVF] = 1'b1;
      end else if (e <= 0) begin
         d = {sign, 31'h0};
         st[ST_UNF] = 1'b1;
      end else begin
         d = {sign, 7'(e), kept[23:0]};
         st[(rem != '0) ? ST_INEXACT : ST_EXACT] = 1'b1;
      end
   endfunction

   // Present operands at a negedge in IDLE, then count cycles until out_valid (-1 on timeout).
   task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                           input logic sel, input logic rnd, output int lat);
      op_a_in     = a;
      op_b_in     = b;
      op_sel      = sel;
      rnd_mode_in = rnd;
      in_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= MAX_WAIT; k++) begin
         if (out_valid) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic sel, input logic rnd,
                         output logic [31:0] d, output logic [3:0] st, output int lat);
      start_op(a, b, sel, rnd, lat);
      d  = data_out;
      st = status_out;
      if (lat > 0) begin
         out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready = 1'b0;
         check("out_valid drop", 64'(out_valid), 64'(0));
      end
   endtask

   initial begin
      logic [31:0] d, exp_d, a, b;
      logic [3:0]  st, exp_st;
      logic        sel, rnd, seen;
      int          lat, ea, eb, kind;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a_in = '0; op_b_in = '0; op_sel = 1'b0; rnd_mode_in = RND_RNE;
      repeat (2) @(negedge clk);
      check("reset in_ready",  64'(in_ready),   64'(1));
      check("reset out_valid", 64'(out_valid),  64'(0));
      check("reset data",      64'(data_out),   64'(0));
      check("reset status",    64'(status_out), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // 1.0 + 1.0
      run_op({1'b0, 7'd63, 24'h0}, {1'b0, 7'd63, 24'h0}, 1'b0, RND_RNE, d, st, lat);
      check("1+1 data",    64'(d),   64'({1'b0, 7'd64, 24'h0}));
      check("1+1 status",  64'(st),  64'(4'b0001));
      check("1+1 latency", 64'(lat), 64'(LAT));

      // 1.5 - 1.5: exact cancellation
      run_op({1'b0, 7'd63, 24'h800000}, {1'b0, 7'd63, 24'h800000}, 1'b1, RND_RNE, d, st, lat);
      check("cancel data",   64'(d),  64'(32'h0));
      check("cancel status", 64'(st), 64'(4'b0001));

      // Largest finite + itself saturates
      run_op({1'b0, 7'd126, 24'hffffff}, {1'b0, 7'd126, 24'hffffff}, 1'b0, RND_RNE, d, st, lat);
      check("ovf data",   64'(d),  64'({1'b0, 7'h7f, 24'h0}));
      check("ovf status", 64'(st), 64'(4'b0010));

      // Rounding mode: B is 0.75 ulp of 1.0
      run_op({1'b0, 7'd63, 24'h0}, {1'b0, 7'd38, 24'h800000}, 1'b0, RND_RNE, d, st, lat);
      check("rne data",   64'(d),  64'({1'b0, 7'd63, 24'h000001}));
      check("rne status", 64'(st), 64'(4'b1000));
      run_op({1'b0, 7'd63, 24'h0}, {1'b0, 7'd38, 24'h800000}, 1'b0, RND_TRUNC, d, st, lat);
      check("trunc data",   64'(d),  64'({1'b0, 7'd63, 24'h0}));
      check("trunc status", 64'(st), 64'(4'b1000));

      // Underflow below the smallest exponent
      run_op({1'b0, 7'd1, 24'h800000}, {1'b0, 7'd1, 24'h0}, 1'b1, RND_RNE, d, st, lat);
      check("unf data",   64'(d),  64'(32'h0));
      check("unf status", 64'(st), 64'(4'b0100));

      // Zero operand passes the other through, sign-adjusted
      run_op({1'b0, 7'd0, 24'h0}, {1'b0, 7'd70, 24'h123456}, 1'b1, RND_RNE, d, st, lat);
      check("zero-a data",   64'(d),  64'({1'b1, 7'd70, 24'h123456}));
      check("zero-a status", 64'(st), 64'(4'b0001));

      // Backpressure: result held, busy, extra in_valid ignored
      a = {1'b0, 7'd65, 24'h400000};
      b = {1'b1, 7'd60, 24'h0ff0f1};
      ref_model(a, b, 1'b0, RND_RNE, exp_d, exp_st);
      start_op(a, b, 1'b0, RND_RNE, lat);
      check("bp latency", 64'(lat), 64'(LAT));
      op_a_in  = {1'b0, 7'd90, 24'h0};
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("bp hold data %0d", k),  64'(data_out),   64'(exp_d));
         check($sformatf("bp hold status %0d", k), 64'(status_out), 64'(exp_st));
         check($sformatf("bp in_ready %0d", k),   64'(in_ready),   64'(0));
         check($sformatf("bp out_valid %0d", k),  64'(out_valid),  64'(1));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("bp idle out_valid", 64'(out_valid), 64'(0));
      check("bp idle in_ready",  64'(in_ready),  64'(1));
      check("bp idle data kept", 64'(data_out),  64'(exp_d));
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("bp no ghost result", 64'(seen), 64'(0));

      // Reset while the op sits in ADD
      op_a_in = {1'b0, 7'd63, 24'h0}; op_b_in = {1'b0, 7'd63, 24'h0};
      op_sel = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst in_ready",  64'(in_ready),   64'(1));
      check("midrst out_valid", 64'(out_valid),  64'(0));
      check("midrst data",      64'(data_out),   64'(0));
      check("midrst status",    64'(status_out), 64'(0));
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("midrst nothing emitted", 64'(seen), 64'(0));

      run_op({1'b1, 7'd63, 24'h0}, {1'b1, 7'd63, 24'h0}, 1'b0, RND_RNE, d, st, lat);
      check("post-rst data",   64'(d),  64'({1'b1, 7'd64, 24'h0}));
      check("post-rst status", 64'(st), 64'(4'b0001));

      // Randomized operands against the model
      for (int i = 0; i < 48; i++) begin
         kind = int'($urandom_range(0, 11));
         ea   = int'($urandom_range(1, 126));
         eb   = ea + int'($urandom_range(0, 60)) - 30;
         if (eb < 1)   eb = 1;
         if (eb > 126) eb = 126;
         if (kind == 2 || kind == 3) eb = ea;
         if (kind == 4) eb = (ea > 1) ? ea - 1 : ea + 1;
         if (kind == 0) ea = 0;
         if (kind == 1) eb = 127;
         a = {1'($urandom), 7'(ea), 24'($urandom)};
         b = {1'($urandom), 7'(eb), 24'($urandom)};
         if (kind == 3) b[23:0] = a[23:0] ^ 24'($urandom_range(0, 255));
         sel = 1'($urandom);
         rnd = 1'($urandom);
         ref_model(a, b, sel, rnd, exp_d, exp_st);
         run_op(a, b, sel, rnd, d, st, lat);
         check($sformatf("rnd%0d data a=%h b=%h sel=%0d rnd=%0d", i, a, b, sel, rnd),
               64'(d), 64'(exp_d));
         check($sformatf("rnd%0d status", i), 64'(st), 64'(exp_st));
         check($sformatf("rnd%0d latency", i), 64'(lat), 64'(LAT));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpu_addsub_pipe.md
Name: fpu_addsub_pipe

Overview:
- Parametrised, handshaked successor to the team's single-cycle FPU adder/subtractor.
- Operand format is generic: 1 sign bit, EXP_W exponent bits, FRAC_W fraction bits. Defaults match the current 32-bit 1/7/24 word.
- One operation is in flight at a time, through a fixed 5-stage FSM: unpack, align, add, normalise, round.
- Adds valid/ready flow control and a selectable rounding mode. Sits between the operand register file and the result writeback.

Parameters:
- EXP_W, 7, exponent width; bias = 2^(EXP_W-1)-1 (63 by default).
- FRAC_W, 24, stored fraction width; hidden leading 1 is implicit.
- W, 1+EXP_W+FRAC_W, total word width (derived; not overridable).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- op_a_in  in  W  operand A; sampled on input handshake
- op_b_in  in  W  operand B; sampled on input handshake
- op_sel  in  1  0 = A+B, 1 = A-B; sampled on input handshake
- rnd_mode_in  in  1  0 = round-to-nearest-even, 1 = truncate; sampled on input handshake
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- data_out  out  W  result
- status_out  out  4  one-hot: [0] EXACT, [1] OVERFLOW, [2] UNDERFLOW, [3] INEXACT
- out_valid  out  1  data_out/status_out valid
- out_ready  in  1  consumer accepts the result

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, data_out=0, status_out=0.
- Reset mid-operation aborts the op; nothing is emitted.
- Number encoding:
  - exp=0 means zero (fraction ignored; no subnormals).
  - exp=all-ones means saturated/overflow value.
  - Otherwise value = (-1)^s * 1.frac * 2^(exp-bias).
- FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - Input handshake is in_valid & in_ready. On handshake, capture operands, op_sel and rnd_mode_in, then go to UNPACK.
- UNPACK:
  - Effective sign of B = sign_b XOR op_sel.
  - Restore the hidden bit.
  - Swap operands so |A| >= |B|, comparing exponent then fraction.
- ALIGN:
  - Right-shift the smaller mantissa by the exponent difference.
  - Keep guard, round and sticky bits. Sticky = OR of all bits shifted beyond round.
  - A difference >= FRAC_W+3 collapses the smaller mantissa to sticky only.
- ADD:
  - Same effective signs: add magnitudes. Otherwise: subtract (larger minus smaller).
  - Result sign = sign of the larger magnitude.
- NORM:
  - Carry-out: shift right 1, exp+1, fold the shifted-out bit into sticky.
  - Otherwise: left shift by the leading-zero count in one cycle, exp-=count.
- ROUND:
  - RNE: increment when G & (R|S|LSB).
  - Truncate: no increment.
  - A rounding carry renormalises (exp+1).
- Result classification (exactly one status bit set):
  - Magnitude zero (exact cancellation): data_out=+0 (all zeros), EXACT.
  - Final exp >= all-ones, or either input exp=all-ones: data_out = sign, exp all-ones, frac 0; OVERFLOW.
  - Final exp <= 0: data_out = signed zero (sign kept, exp 0, frac 0); UNDERFLOW.
  - Otherwise INEXACT if any of G/R/S was nonzero, else EXACT.
- Zero-operand shortcut: the other operand (sign-adjusted) passes through unchanged, EXACT, with the same latency.
- DONE:
  - out_valid=1. data_out and status_out are held stable while out_ready=0.
  - On out_valid & out_ready: go to IDLE next cycle; out_valid drops.
- Latency: out_valid rises 6 cycles after the input handshake edge (5 processing states, then DONE).
- Throughput: one op every 7 cycles at best. in_ready=0 from UNPACK through DONE.
- in_valid while busy is ignored; no queueing.
- data_out and status_out keep their last values while in IDLE.

Decomposition:
- Package fpu_pkg:
  - status bit indices (ST_EXACT=0, ST_OVF=1, ST_UNF=2, ST_INEXACT=3);
  - state enum;
  - rounding-mode constants RND_RNE/RND_TRUNC;
  - bias function bias(EXP_W).
- Sub-module fpu_lzc: combinational leading-zero counter, parametrised in width. Used by NORM.

Test Plan:
- 1.0+1.0: A=B=0_0111111_0…0, sel=0, RNE -> 0_1000000_0…0, status 4'b0001, out_valid 6 cycles after the accept edge.
- 1.5-1.5: A=B=0_0111111_10…0, sel=1 -> data_out 32'h0, status 4'b0001.
- Overflow: A=B=0_1111110_1…1, sel=0 -> 0_1111111_0…0, status 4'b0010.
- Rounding mode:
  - A=1.0 (0_0111111_0…0), B=0_0100110_10…0 (1.5*2^-25), sel=0.
  - RNE -> 0_0111111_0…01, status 4'b1000.
  - Truncate -> 0_0111111_0…0, status 4'b1000.
- Underflow: A=0_0000001_10…0, B=0_0000001_0…0, sel=1 -> 32'h0, status 4'b0100.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles: data_out stable, in_ready=0, a second in_valid is ignored; then accept the result.
  - Assert rst during ADD: out_valid stays 0, in_ready=1, outputs zero.
